// File: rtl/combo_score_tracker.sv
// Rhythm-game scoring: BCD score, current combo and best combo, with a
// registered display mux for the seven-segment driver.
module combo_score_tracker #(
    parameter logic [1:0] STATE_RESET = 2'b00,
    parameter logic [1:0] STATE_PAUSE = 2'b01,
    parameter logic [1:0] STATE_GAME  = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  game_state,
    input  logic        display_combo_en,
    input  logic        hit_valid,
    input  logic        hit_perfect,
    input  logic        miss,
    output logic [15:0] score_bcd,
    output logic [7:0]  combo_bcd,
    output logic [7:0]  max_combo_bcd,
    output logic [15:0] disp_bcd,
    output logic        new_record
);

    // Four-digit BCD add of a small point value; any carry out of the top
    // digit pins the result at 9999 instead of wrapping.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [2:0] pts);
        logic [4:0]  d;
        logic [3:0]  c;
        logic [15:0] r;
        c = {1'b0, pts};
        r = '0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[i*4 +: 4]} + {1'b0, c};
            if (d > 5'd9) begin
                r[i*4 +: 4] = 4'(d - 5'd10);
                c = 4'd1;
            end else begin
                r[i*4 +: 4] = d[3:0];
                c = 4'd0;
            end
        end
        if (c != 4'd0) r = 16'h9999;
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] a);
        logic [7:0] r;
        if (a == 8'h99)
            r = 8'h99;
        else if (a[3:0] == 4'd9)
            r = {a[7:4] + 4'd1, 4'd0};
        else
            r = {a[7:4], a[3:0] + 4'd1};
        return r;
    endfunction

    logic [15:0] score_p0, score_n;
    logic [7:0]  combo_p0, combo_n;
    logic [7:0]  max_p0, max_n;
    logic        rec_p0, rec_n;
    logic        en_p0;
    logic [15:0] disp_p1;
    logic [2:0]  pts;

    always_comb begin
        score_n = score_p0;
        combo_n = combo_p0;
        max_n   = max_p0;
        rec_n   = 1'b0;
        pts     = hit_perfect ? 3'd2 : 3'd1;
        // Any nonzero tens digit means the combo before this hit is >= 10.
        if (combo_p0[7:4] != 4'd0) pts = {pts[1:0], 1'b0};

        if (game_state == STATE_RESET) begin
            score_n = '0;
            combo_n = '0;
            max_n   = '0;
        end else if (game_state == STATE_GAME) begin
            if (miss) begin
                combo_n = '0;
            end else if (hit_valid) begin
                score_n = bcd_add_sat(score_p0, pts);
                combo_n = bcd_inc_sat(combo_p0);
                // Valid BCD orders the same as plain binary.
                if (combo_n > max_p0) begin
                    max_n = combo_n;
                    rec_n = 1'b1;
                end
            end
        end
    end

    // Stage 0: counters and record pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_p0 <= '0;
            combo_p0 <= '0;
            max_p0   <= '0;
            rec_p0   <= 1'b0;
            en_p0    <= 1'b0;
        end else begin
            score_p0 <= score_n;
            combo_p0 <= combo_n;
            max_p0   <= max_n;
            rec_p0   <= rec_n;
            en_p0    <= display_combo_en;
        end
    end

    // Stage 1: display register, fed from the settled counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            disp_p1 <= '0;
        else
            disp_p1 <= en_p0 ? {combo_p0, max_p0} : score_p0;
    end

    assign score_bcd     = score_p0;
    assign combo_bcd     = combo_p0;
    assign max_combo_bcd = max_p0;
    assign new_record    = rec_p0;
    assign disp_bcd      = disp_p1;

endmodule

// File: tb/tb_combo_score_tracker.sv
// Directed bench for combo_score_tracker with hand-computed BCD expectations.
module tb_combo_score_tracker;

    localparam logic [1:0] ST_RESET = 2'b00;
    localparam logic [1:0] ST_PAUSE = 2'b01;
    localparam logic [1:0] ST_GAME  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  game_state;
    logic        display_combo_en;
    logic        hit_valid;
    logic        hit_perfect;
    logic        miss;
    logic [15:0] score_bcd;
    logic [7:0]  combo_bcd;
    logic [7:0]  max_combo_bcd;
    logic [15:0] disp_bcd;
    logic        new_record;

    int tests = 0;
    int fails = 0;

    combo_score_tracker dut (
        .clk              (clk),
        .rst              (rst),
        .game_state       (game_state),
        .display_combo_en (display_combo_en),
        .hit_valid        (hit_valid),
        .hit_perfect      (hit_perfect),
        .miss             (miss),
        .score_bcd        (score_bcd),
        .combo_bcd        (combo_bcd),
        .max_combo_bcd    (max_combo_bcd),
        .disp_bcd         (disp_bcd),
        .new_record       (new_record)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic perfect);
        hit_valid = 1'b1;
        hit_perfect = perfect;
        tick();
        hit_valid = 1'b0;
        hit_perfect = 1'b0;
    endtask

    task automatic clear_game();
        game_state = ST_RESET;
        tick();
        game_state = ST_GAME;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (score_bcd !== 16'h0000) begin fails++; $display("FAIL reset_score got %h exp 0000", score_bcd); end
        tests++; if (combo_bcd !== 8'h00) begin fails++; $display("FAIL reset_combo got %h exp 00", combo_bcd); end
        tests++; if (max_combo_bcd !== 8'h00) begin fails++; $display("FAIL reset_max got %h exp 00", max_combo_bcd); end
        tests++; if (disp_bcd !== 16'h0000) begin fails++; $display("FAIL reset_disp got %h exp 0000", disp_bcd); end
        tests++; if (new_record !== 1'b0) begin fails++; $display("FAIL reset_rec got %b exp 0", new_record); end
        tick();
        rst = 1'b0;
        game_state = ST_GAME;
    endtask

    task automatic test_twelve_hits();
        clear_game();
        for (int i = 0; i < 12; i++) hit(1'b1);
        tests++; if (score_bcd !== 16'h0028) begin fails++; $display("FAIL twelve_score got %h exp 0028", score_bcd); end
        tests++; if (combo_bcd !== 8'h12) begin fails++; $display("FAIL twelve_combo got %h exp 12", combo_bcd); end
        tests++; if (max_combo_bcd !== 8'h12) begin fails++; $display("FAIL twelve_max got %h exp 12", max_combo_bcd); end
        tests++; if (new_record !== 1'b1) begin fails++; $display("FAIL twelve_rec got %b exp 1", new_record); end
        tick();
        tests++; if (new_record !== 1'b0) begin fails++; $display("FAIL twelve_rec_pulse got %b exp 0", new_record); end
        tests++; if (disp_bcd !== 16'h0028) begin fails++; $display("FAIL twelve_disp got %h exp 0028", disp_bcd); end
    endtask

    task automatic test_miss();
        miss = 1'b1;
        tick();
        miss = 1'b0;
        tests++; if (combo_bcd !== 8'h00) begin fails++; $display("FAIL miss_combo got %h exp 00", combo_bcd); end
        tests++; if (score_bcd !== 16'h0028) begin fails++; $display("FAIL miss_score got %h exp 0028", score_bcd); end
        tests++; if (max_combo_bcd !== 8'h12) begin fails++; $display("FAIL miss_max got %h exp 12", max_combo_bcd); end
        hit(1'b0);
        tests++; if (score_bcd !== 16'h0029) begin fails++; $display("FAIL miss_good_score got %h exp 0029", score_bcd); end
        tests++; if (new_record !== 1'b0) begin fails++; $display("FAIL miss_good_rec got %b exp 0", new_record); end
    endtask

    task automatic test_hit_miss_same();
        clear_game();
        for (int i = 0; i < 5; i++) hit(1'b1);
        tests++; if (combo_bcd !== 8'h05) begin fails++; $display("FAIL both_pre_combo got %h exp 05", combo_bcd); end
        hit_valid = 1'b1; hit_perfect = 1'b1; miss = 1'b1;
        tick();
        hit_valid = 1'b0; hit_perfect = 1'b0; miss = 1'b0;
        tests++; if (combo_bcd !== 8'h00) begin fails++; $display("FAIL both_combo got %h exp 00", combo_bcd); end
        tests++; if (score_bcd !== 16'h0010) begin fails++; $display("FAIL both_score got %h exp 0010", score_bcd); end
        hit(1'b1);
        tests++; if (combo_bcd !== 8'h01) begin fails++; $display("FAIL both_next_combo got %h exp 01", combo_bcd); end
        tests++; if (max_combo_bcd !== 8'h05) begin fails++; $display("FAIL both_next_max got %h exp 05", max_combo_bcd); end
        tests++; if (new_record !== 1'b0) begin fails++; $display("FAIL both_next_rec got %b exp 0", new_record); end
        tests++; if (score_bcd !== 16'h0012) begin fails++; $display("FAIL both_next_score got %h exp 0012", score_bcd); end
    endtask

    task automatic test_pause_display();
        clear_game();
        for (int i = 0; i < 15; i++) hit(1'b1);
        miss = 1'b1; tick(); miss = 1'b0;
        for (int i = 0; i < 7; i++) hit(1'b1);
        game_state = ST_PAUSE;
        for (int i = 0; i < 3; i++) begin hit(1'b1); tick(); end
        tests++; if (score_bcd !== 16'h0054) begin fails++; $display("FAIL pause_score got %h exp 0054", score_bcd); end
        tests++; if (combo_bcd !== 8'h07) begin fails++; $display("FAIL pause_combo got %h exp 07", combo_bcd); end
        tests++; if (max_combo_bcd !== 8'h15) begin fails++; $display("FAIL pause_max got %h exp 15", max_combo_bcd); end
        game_state = 2'b11;
        hit(1'b1);
        tests++; if (combo_bcd !== 8'h07) begin fails++; $display("FAIL hold11_combo got %h exp 07", combo_bcd); end
        tests++; if (new_record !== 1'b0) begin fails++; $display("FAIL hold11_rec got %b exp 0", new_record); end
        game_state = ST_PAUSE;
        display_combo_en = 1'b1;
        tick();
        tick();
        tests++; if (disp_bcd !== 16'h0715) begin fails++; $display("FAIL disp_combo got %h exp 0715", disp_bcd); end
        display_combo_en = 1'b0;
        tick();
        tick();
        tests++; if (disp_bcd !== 16'h0054) begin fails++; $display("FAIL disp_score got %h exp 0054", disp_bcd); end
        game_state = ST_GAME;
    endtask

    task automatic test_combo_sat();
        clear_game();
        for (int i = 0; i < 99; i++) hit(1'b0);
        tests++; if (combo_bcd !== 8'h99) begin fails++; $display("FAIL sat99_combo got %h exp 99", combo_bcd); end
        tests++; if (score_bcd !== 16'h0188) begin fails++; $display("FAIL sat99_score got %h exp 0188", score_bcd); end
        tests++; if (new_record !== 1'b1) begin fails++; $display("FAIL sat99_rec got %b exp 1", new_record); end
        hit(1'b1);
        tests++; if (combo_bcd !== 8'h99) begin fails++; $display("FAIL over99_combo got %h exp 99", combo_bcd); end
        tests++; if (score_bcd !== 16'h0192) begin fails++; $display("FAIL over99_score got %h exp 0192", score_bcd); end
        tests++; if (max_combo_bcd !== 8'h99) begin fails++; $display("FAIL over99_max got %h exp 99", max_combo_bcd); end
        tests++; if (new_record !== 1'b0) begin fails++; $display("FAIL over99_rec got %b exp 0", new_record); end
        game_state = ST_RESET;
        tick();
        tests++; if (score_bcd !== 16'h0000) begin fails++; $display("FAIL clear_score got %h exp 0000", score_bcd); end
        tests++; if (combo_bcd !== 8'h00) begin fails++; $display("FAIL clear_combo got %h exp 00", combo_bcd); end
        tests++; if (max_combo_bcd !== 8'h00) begin fails++; $display("FAIL clear_max got %h exp 00", max_combo_bcd); end
        game_state = ST_GAME;
    endtask

    task automatic test_score_sat();
        clear_game();
        for (int i = 0; i < 10; i++) hit(1'b1);
        hit(1'b0);
        tests++; if (score_bcd !== 16'h0022) begin fails++; $display("FAIL presat_score got %h exp 0022", score_bcd); end
        for (int i = 0; i < 2494; i++) hit(1'b1);
        tests++; if (score_bcd !== 16'h9998) begin fails++; $display("FAIL preload_score got %h exp 9998", score_bcd); end
        hit(1'b1);
        tests++; if (score_bcd !== 16'h9999) begin fails++; $display("FAIL sat_score got %h exp 9999", score_bcd); end
        hit(1'b1);
        tests++; if (score_bcd !== 16'h9999) begin fails++; $display("FAIL sat_hold_score got %h exp 9999", score_bcd); end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b1;
        #1;
        tests++; if (score_bcd !== 16'h0000) begin fails++; $display("FAIL arst_score got %h exp 0000", score_bcd); end
        tests++; if (combo_bcd !== 8'h00) begin fails++; $display("FAIL arst_combo got %h exp 00", combo_bcd); end
        tests++; if (max_combo_bcd !== 8'h00) begin fails++; $display("FAIL arst_max got %h exp 00", max_combo_bcd); end
        tests++; if (disp_bcd !== 16'h0000) begin fails++; $display("FAIL arst_disp got %h exp 0000", disp_bcd); end
        hit_valid = 1'b1; hit_perfect = 1'b1;
        tick();
        tick();
        tests++; if (combo_bcd !== 8'h00) begin fails++; $display("FAIL arst_hold_combo got %h exp 00", combo_bcd); end
        tests++; if (score_bcd !== 16'h0000) begin fails++; $display("FAIL arst_hold_score got %h exp 0000", score_bcd); end
        rst = 1'b0;
        tick();
        hit_valid = 1'b0; hit_perfect = 1'b0;
        tests++; if (combo_bcd !== 8'h01) begin fails++; $display("FAIL resume_combo got %h exp 01", combo_bcd); end
        tests++; if (score_bcd !== 16'h0002) begin fails++; $display("FAIL resume_score got %h exp 0002", score_bcd); end
        tests++; if (new_record !== 1'b1) begin fails++; $display("FAIL resume_rec got %b exp 1", new_record); end
    endtask

    initial begin
        rst = 1'b1;
        game_state = ST_RESET;
        display_combo_en = 1'b0;
        hit_valid = 1'b0;
        hit_perfect = 1'b0;
        miss = 1'b0;
        test_reset();
        test_twelve_hits();
        test_miss();
        test_hit_miss_same();
        test_pause_display();
        test_combo_sat();
        test_score_sat();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
